mult_scheduler: RTL and testbench

//  Shares one 8x8 signed shift-add multiplier datapath (A/B/X registers, 9-bit adder) among NUM_REQ requesters.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_scheduler_if.sv | 26 ++
 rtl/mult_scheduler_rr_arbiter.sv | 40 ++++
 rtl/mult_scheduler.sv | 151 +++++++++++++++
 tb/tb_mult_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared widths, sequencer states and job payload for the multiplier scheduler.
package mult_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ITER   = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    OP,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } job_t;

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester-side request/response bundle of the multiplier scheduler.
interface mult_scheduler_if
  import mult_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [PROD_W-1:0]       rsp_prod;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod
  );

endinterface

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last winner; pointer moves only on advance.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_c
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] pick_c;
  logic             hit_c;
  int unsigned      idx;

  // Walk from farthest to nearest so the requester just after last_q wins.
  always_comb begin
    pick_c = last_q;
    hit_c  = 1'b0;
    idx    = 0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = 32'(last_q) + 32'(i);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PTR_W'(idx)]) begin
        hit_c  = 1'b1;
        pick_c = PTR_W'(idx);
      end
    end
    grant_c = hit_c ? (NUM_REQ'(1) << pick_c) : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) last_q <= PTR_W'(NUM_REQ - 1);
    else if (advance && hit_c) last_q <= pick_c;
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one 8x8 signed shift-add multiplier datapath among NUM_REQ requesters.
// Optional MULT_ZERO_SKIP_EN: jobs with a zero operand bypass the datapath.
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  mult_scheduler_if.slave   bus,
  output logic              Ld_B,
  output logic              Ld_A,
  output logic              Ld_Sub,
  output logic              Shift_En,
  output logic [OP_W-1:0]   dp_s,
  output logic [OP_W-1:0]   dp_b,
  input  logic              M,
  input  logic [PROD_W-1:0] dp_prod
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ready_q;
  logic [NUM_REQ-1:0] valid_q;
  logic [PROD_W-1:0]  prod_q;
  logic [NUM_REQ-1:0] grant_c;
  job_t               sel_c;
`ifdef MULT_ZERO_SKIP_EN
  logic               zero_q;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req     (bus.req_valid),
    .advance (state == IDLE),
    .grant_c (grant_c)
  );

  always_comb begin
    sel_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_c[i]) begin
        sel_c.a = bus.req_a[i*OP_W +: OP_W];
        sel_c.b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  // Strobes are registered for the state being entered; during a SHIFT, dp_prod[1] is B[0] after the shift.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_q    <= '0;
      ready_q  <= '0;
      valid_q  <= '0;
      prod_q   <= '0;
      Ld_B     <= 1'b0;
      Ld_A     <= 1'b0;
      Ld_Sub   <= 1'b0;
      Shift_En <= 1'b0;
      dp_s     <= '0;
      dp_b     <= '0;
`ifdef MULT_ZERO_SKIP_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      ready_q  <= '0;
      Ld_B     <= 1'b0;
      Ld_A     <= 1'b0;
      Ld_Sub   <= 1'b0;
      Shift_En <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant_c) begin
            ready_q <= grant_c;
            gnt_q   <= grant_c;
            dp_s    <= sel_c.a;
            dp_b    <= sel_c.b;
`ifdef MULT_ZERO_SKIP_EN
            zero_q  <= (sel_c.a == '0) || (sel_c.b == '0);
            if ((sel_c.a == '0) || (sel_c.b == '0)) begin
              state <= DONE;
            end else begin
              state <= LOAD;
              Ld_B  <= 1'b1;
            end
`else
            state   <= LOAD;
            Ld_B    <= 1'b1;
`endif
          end
        end
        LOAD: begin
          cnt <= '0;
          if (dp_b[0]) begin
            state <= OP;
            Ld_A  <= 1'b1;
          end else begin
            state    <= SHIFT;
            Shift_En <= 1'b1;
          end
        end
        OP: begin
          state    <= SHIFT;
          Shift_En <= 1'b1;
        end
        SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= DONE;
          end else if (dp_prod[1]) begin
            state <= OP;
            if (cnt == CNT_W'(ITER - 2)) Ld_Sub <= 1'b1;
            else Ld_A <= 1'b1;
          end else begin
            Shift_En <= 1'b1;
          end
        end
        DONE: begin
          if (valid_q == '0) begin
`ifdef MULT_ZERO_SKIP_EN
            prod_q <= zero_q ? '0 : dp_prod;
`else
            prod_q <= dp_prod;
`endif
            valid_q <= gnt_q;
          end else if (|(valid_q & bus.rsp_ready)) begin
            valid_q <= '0;
            dp_s    <= '0;
            dp_b    <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath B[0] must agree with the multiplier bit that steered us into OP.
  always_ff @(posedge Clk) begin
    if (Reset_n && state == OP) assert (M);
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_prod  = prod_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a behavioural shift-add datapath attached.
module tb_mult_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Ld_B, Ld_A, Ld_Sub, Shift_En;
  logic [7:0]  dp_s, dp_b;
  logic        M;
  logic [15:0] dp_prod;

  logic [7:0]  dA = '0;
  logic [7:0]  dB = '0;
  logic        dX = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_lda = 0, n_sub = 0, n_sh = 0, n_ldb = 0, sub_at = 0, n_excl = 0;

  mult_scheduler_if #(.NUM_REQ(2)) bus ();

  mult_scheduler #(.NUM_REQ(2)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .bus      (bus),
    .Ld_B     (Ld_B),
    .Ld_A     (Ld_A),
    .Ld_Sub   (Ld_Sub),
    .Shift_En (Shift_En),
    .dp_s     (dp_s),
    .dp_b     (dp_b),
    .M        (M),
    .dp_prod  (dp_prod)
  );

  initial forever #5 Clk = ~Clk;

  // X:A:B datapath driven only by the strobes.
  always @(posedge Clk) begin
    if (Ld_B) begin
      dB <= dp_b; dA <= '0; dX <= 1'b0;
    end else if (Ld_A) begin
      {dX, dA} <= {dA[7], dA} + {dp_s[7], dp_s};
    end else if (Ld_Sub) begin
      {dX, dA} <= {dA[7], dA} - {dp_s[7], dp_s};
    end else if (Shift_En) begin
      dA <= {dX, dA[7:1]};
      dB <= {dA[0], dB[7:1]};
    end
  end
  assign M       = dB[0];
  assign dp_prod = {dA, dB};

  always @(posedge Clk) begin
    n_lda <= n_lda + int'(Ld_A);
    n_sub <= n_sub + int'(Ld_Sub);
    n_sh  <= n_sh + int'(Shift_En);
    n_ldb <= n_ldb + int'(Ld_B);
    if (Ld_Sub) sub_at <= n_sh;
    if (int'(Ld_B) + int'(Ld_A) + int'(Ld_Sub) + int'(Shift_En) > 1) n_excl <= n_excl + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp_g);
    int n = 0;
    while (bus.req_ready == '0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " grant"}, 32'(bus.req_ready), 32'(exp_g));
  endtask

  task automatic wait_rsp(output int lat);
    int n = 0;
    while (bus.rsp_valid == '0 && n < 60) begin
      tick();
      n++;
    end
    lat = n;
  endtask

  task automatic accept(input string tag, input logic [1:0] oh);
    bus.rsp_ready = oh;
    tick();
    bus.rsp_ready = '0;
    check({tag, " rsp cleared"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  task automatic run_job(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int exp_lat,
                         output int d_a, output int d_sub, output int d_sh, output int d_ldb,
                         output int d_subpos);
    int lat;
    int s_a, s_sub, s_sh, s_ldb;
    logic [1:0] oh;
    oh = 2'(1 << r);
    s_a = n_lda; s_sub = n_sub; s_sh = n_sh; s_ldb = n_ldb;
    bus.req_a[r*8 +: 8] = a;
    bus.req_b[r*8 +: 8] = b;
    bus.req_valid[r] = 1'b1;
    wait_grant(tag, oh);
    bus.req_valid[r] = 1'b0;
    wait_rsp(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
    check({tag, " prod"}, 32'(bus.rsp_prod), 32'(exp_p));
    d_a = n_lda - s_a; d_sub = n_sub - s_sub; d_sh = n_sh - s_sh; d_ldb = n_ldb - s_ldb;
    d_subpos = sub_at - s_sh;
    accept(tag, oh);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int da, dsub, dsh, dldb, dpos, lat, n;
    logic ok;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = '0;
    do_reset();

    check("reset handshake", 32'({bus.req_ready, bus.rsp_valid}), 32'h0);
    check("reset strobes", 32'({Ld_B, Ld_A, Ld_Sub, Shift_En}), 32'h0);
    check("reset dp/prod", 32'({dp_s, dp_b, bus.rsp_prod}), 32'h0);

    // 7*5: two adds, eight shifts
    run_job("t1 7*5", 0, 8'd7, 8'd5, 16'h0023, 12, da, dsub, dsh, dldb, dpos);
    check("t1 Ld_A", 32'(da), 32'd2);
    check("t1 Shift_En", 32'(dsh), 32'd8);
    check("t1 Ld_B", 32'(dldb), 32'd1);
    check("t1 Ld_Sub", 32'(dsub), 32'd0);

    run_job("t2 -3*4", 1, 8'hFD, 8'h04, 16'hFFF4, 11, da, dsub, dsh, dldb, dpos);
    check("t2a Ld_Sub", 32'(dsub), 32'd0);
    run_job("t2 4*-3", 1, 8'h04, 8'hFD, 16'hFFF4, 17, da, dsub, dsh, dldb, dpos);
    check("t2b Ld_Sub", 32'(dsub), 32'd1);
    check("t2b sub iteration", 32'(dpos), 32'd7);
    check("t2b Ld_A", 32'(da), 32'd6);

    run_job("t3 -128*-128", 0, 8'h80, 8'h80, 16'h4000, 11, da, dsub, dsh, dldb, dpos);
    run_job("t3 127*-128", 1, 8'h7F, 8'h80, 16'hC080, 11, da, dsub, dsh, dldb, dpos);

`ifdef MULT_ZERO_SKIP_EN
    run_job("zero 0*9", 0, 8'h00, 8'h09, 16'h0000, 1, da, dsub, dsh, dldb, dpos);
    check("zero strobes", 32'(da + dsub + dsh + dldb), 32'd0);
`else
    run_job("zero 0*9", 0, 8'h00, 8'h09, 16'h0000, 12, da, dsub, dsh, dldb, dpos);
    check("zero shifts", 32'(dsh), 32'd8);
`endif

    // Reset while shifting aborts the job silently
    bus.req_a[7:0] = 8'd5;
    bus.req_b[7:0] = 8'd3;
    bus.req_valid[0] = 1'b1;
    wait_grant("t6", 2'b01);
    bus.req_valid[0] = 1'b0;
    n = 0;
    while (!Shift_En && n < 40) begin tick(); n++; end
    check("t6 in shift", 32'(Shift_En), 32'h1);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    check("t6 reset handshake", 32'({bus.req_ready, bus.rsp_valid}), 32'h0);
    check("t6 reset strobes", 32'({Ld_B, Ld_A, Ld_Sub, Shift_En}), 32'h0);
    check("t6 reset dp/prod", 32'({dp_s, dp_b, bus.rsp_prod}), 32'h0);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.rsp_valid != '0 || {Ld_B, Ld_A, Ld_Sub, Shift_En} != 4'h0) ok = 1'b0;
    end
    check("t6 no response", 32'(ok), 32'h1);
    run_job("t6 6*6", 0, 8'd6, 8'd6, 16'h0024, 12, da, dsub, dsh, dldb, dpos);

    // Two requesters held together: strict rotation, nothing granted while a response waits
    do_reset();
    bus.req_a = {8'hFE, 8'h03};
    bus.req_b = {8'h03, 8'h02};
    bus.req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      logic [1:0] eg;
      eg = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant("t4", eg);
      wait_rsp(lat);
      check("t4 rsp_valid", 32'(bus.rsp_valid), 32'(eg));
      check("t4 prod", 32'(bus.rsp_prod), (eg == 2'b01) ? 32'h0006 : 32'hFFFA);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (bus.req_ready != '0) ok = 1'b0;
      end
      check("t4 no grant in DONE", 32'(ok), 32'h1);
      accept("t4", eg);
    end
    bus.req_valid = '0;

    // Back-pressure: response stays put, competing request waits
    bus.req_a = {8'h01, 8'h09};
    bus.req_b = {8'h01, 8'h03};
    bus.req_valid = 2'b11;
    wait_grant("t5", 2'b01);
    bus.req_valid[0] = 1'b0;
    wait_rsp(lat);
    check("t5 latency", 32'(lat), 32'd12);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid != 2'b01 || bus.rsp_prod != 16'h001B || bus.req_ready != '0) ok = 1'b0;
      tick();
    end
    check("t5 held stable", 32'(ok), 32'h1);
    check("t5 prod", 32'(bus.rsp_prod), 32'h001B);
    accept("t5 r0", 2'b01);
    wait_grant("t5 r1", 2'b10);
    bus.req_valid[1] = 1'b0;
    wait_rsp(lat);
    check("t5 r1 prod", 32'(bus.rsp_prod), 32'h0001);
    accept("t5 r1", 2'b10);

    check("strobe exclusivity", 32'(n_excl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
